// File: rtl/sync_tx.sv
// Byte-serial command framer: SOF, four payload bytes, optional XOR checksum byte.
// Define SYNC_TX_CHK_EN to append the checksum byte; by default it is left out.
module sync_tx #(
    parameter logic [7:0] SOF       = 8'hA5,
    parameter int         STALL_MAX = 1023
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic [31:0] cmd_data,
    input  logic [1:0]  cmd_ch,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  nTF,
    output logic [7:0]  D,
    output logic        nTx,
    output logic [15:0] tx_count,
    output logic        err
);

    localparam int SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

`ifdef SYNC_TX_CHK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_PAY, ST_CHK} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_PAY} state_t;
`endif

    state_t          state, state_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [SW-1:0]   stall_cnt, stall_nxt;
    logic [31:0]     data_q;
    logic [1:0]      ch_q;
    logic [7:0]      d_nxt, cur_byte;
    logic            ntx_nxt, err_nxt, go;
    logic [15:0]     cnt_nxt;

    assign cmd_ready = (state == ST_IDLE) && !rst;

    // Payload and channel are captured once per frame; they need no reset.
    always_ff @(posedge clk_100) begin
        if (state == ST_IDLE && cmd_valid) begin
            data_q <= cmd_data;
            ch_q   <= cmd_ch;
        end
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            stall_cnt <= '0;
            D         <= 8'h00;
            nTx       <= 1'b1;
            tx_count  <= 16'h0000;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            stall_cnt <= stall_nxt;
            D         <= d_nxt;
            nTx       <= ntx_nxt;
            tx_count  <= cnt_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        go = 1'b0;
        case (ch_q)
            2'd0:    go = nTF[0];
            2'd1:    go = nTF[1];
            2'd2:    go = nTF[2];
            default: go = &nTF;
        endcase
    end

    always_comb begin
        cur_byte = D;
        case (state)
            ST_SOF: cur_byte = SOF;
            ST_PAY: begin
                case (idx)
                    2'd0:    cur_byte = data_q[31:24];
                    2'd1:    cur_byte = data_q[23:16];
                    2'd2:    cur_byte = data_q[15:8];
                    default: cur_byte = data_q[7:0];
                endcase
            end
`ifdef SYNC_TX_CHK_EN
            ST_CHK: cur_byte = data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
`endif
            default: cur_byte = D;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        stall_nxt = stall_cnt;
        d_nxt     = D;
        ntx_nxt   = 1'b1;
        cnt_nxt   = tx_count;
        err_nxt   = err;
        if (state == ST_IDLE) begin
            stall_nxt = '0;
            if (cmd_valid) begin
                state_nxt = ST_SOF;
                idx_nxt   = 2'd0;
            end
        end else if (go) begin
            d_nxt     = cur_byte;
            ntx_nxt   = 1'b0;
            stall_nxt = '0;
            case (state)
                ST_SOF: begin
                    state_nxt = ST_PAY;
                    idx_nxt   = 2'd0;
                end
                ST_PAY: begin
                    if (idx == 2'd3) begin
`ifdef SYNC_TX_CHK_EN
                        state_nxt = ST_CHK;
`else
                        state_nxt = ST_IDLE;
                        cnt_nxt   = tx_count + 16'd1;
`endif
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
`ifdef SYNC_TX_CHK_EN
                ST_CHK: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = tx_count + 16'd1;
                end
`endif
                default: state_nxt = ST_IDLE;
            endcase
        end else if (stall_cnt == STALL_LAST) begin
            // This stall cycle is the STALL_MAX-th in a row: give up on the frame.
            state_nxt = ST_IDLE;
            stall_nxt = '0;
            err_nxt   = 1'b1;
        end else begin
            stall_nxt = stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_tx.sv
// Self-checking bench for sync_tx: directed frames, stalls, abort, reset and wrap,
// plus randomized frames checked against a byte-list model of the frame format.
module tb_sync_tx;

    localparam int STALL_MAX = 15;
`ifdef SYNC_TX_CHK_EN
    localparam int N = 6;
`else
    localparam int N = 5;
`endif

    logic        clk_100 = 1'b0;
    logic        rst;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_ch;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  nTF;
    logic [7:0]  D;
    logic        nTx;
    logic [15:0] tx_count;
    logic        err;

    always #5 clk_100 = ~clk_100;

    sync_tx #(.SOF(8'hA5), .STALL_MAX(STALL_MAX)) dut (
        .clk_100  (clk_100),
        .rst      (rst),
        .cmd_data (cmd_data),
        .cmd_ch   (cmd_ch),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .nTF      (nTF),
        .D        (D),
        .nTx      (nTx),
        .tx_count (tx_count),
        .err      (err)
    );

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  got[$];
    logic [7:0]  last_d;
    logic [1:0]  cur_ch;
    logic [15:0] model_count;
    int          cyc, first_cyc, last_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic go_of(input logic [2:0] f, input logic [1:0] ch);
        case (ch)
            2'd0:    return f[0];
            2'd1:    return f[1];
            2'd2:    return f[2];
            default: return f[0] & f[1] & f[2];
        endcase
    endfunction

    function automatic logic [2:0] rand_ntf();
        logic [2:0] f;
        for (int b = 0; b < 3; b++) f[b] = ($urandom_range(7) != 0);
        return f;
    endfunction

    // One clock: the flags seen now decide the byte that appears after the edge.
    task automatic step();
        logic gp;
        gp = go_of(nTF, cur_ch);
        @(negedge clk_100);
        cyc++;
        if (nTx === 1'b0) begin
            check("go_before_byte", {31'd0, gp}, 32'd1);
            got.push_back(D);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end else begin
            check("d_hold", {24'd0, D}, {24'd0, last_d});
        end
        last_d = D;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_frame(input logic [31:0] data, input logic [1:0] ch, input bit rnd,
                             input int stall_at, input int stall_len, input logic [2:0] stall_mask);
        logic [7:0] exp_q[$];
        int         stall_rem;
        bit         stalled;
        exp_q = '{8'hA5, data[31:24], data[23:16], data[15:8], data[7:0]};
`ifdef SYNC_TX_CHK_EN
        exp_q.push_back(data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0]);
`endif
        wait_ready();
        cmd_data  = data;
        cmd_ch    = ch;
        cmd_valid = 1'b1;
        cur_ch    = ch;
        got.delete();
        cyc = 0; first_cyc = -1; last_cyc = -1;
        stall_rem = 0; stalled = 0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < N + 40 && got.size() < N; i++) begin
            if (stall_len > 0 && !stalled && got.size() == stall_at) begin
                stalled = 1;
                stall_rem = stall_len;
            end
            if (stall_rem > 0) begin
                nTF = stall_mask;
                stall_rem--;
            end else begin
                nTF = rnd ? rand_ntf() : 3'b111;
            end
            step();
        end
        check("frame_len", got.size(), N);
        for (int i = 0; i < N && i < got.size(); i++)
            check($sformatf("frame_byte%0d", i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        check("ready_after_frame", {31'd0, cmd_ready}, 32'd1);
        model_count = model_count + 16'd1;
        check("tx_count", {16'd0, tx_count}, {16'd0, model_count});
        if (!rnd) begin
            check("first_byte_cycle", first_cyc, 2);
            check("last_byte_cycle", last_cyc, N + 1 + stall_len);
            check("stall_gap", last_cyc - first_cyc + 1 - N, stall_len);
        end
        nTF = 3'b111;
    endtask

    initial begin
        int err_cyc;
        rst = 1'b1; cmd_data = '0; cmd_ch = '0; cmd_valid = 1'b0; nTF = 3'b111;
        cur_ch = 2'd0; last_d = 8'h00; model_count = 16'h0000; cyc = 0;
        first_cyc = -1; last_cyc = -1;
        repeat (2) @(negedge clk_100);
        check("rst_ntx", {31'd0, nTx}, 32'd1);
        check("rst_d", {24'd0, D}, 32'h00);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_count", {16'd0, tx_count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Clean frame, then the same frame stalled for three cycles after byte 34.
        run_frame(32'h12345678, 2'd0, 0, 0, 0, 3'b111);
        check("count_one", {16'd0, tx_count}, 32'd1);
        run_frame(32'h12345678, 2'd0, 0, 3, 3, 3'b110);
        run_frame(32'hDEADBEEF, 2'd1, 0, 0, 0, 3'b111);
        run_frame(32'hCAFEF00D, 2'd3, 0, 2, 5, 3'b011);

        for (int k = 0; k < 12; k++)
            run_frame($urandom, 2'($urandom_range(3)), 1, 0, 0, 3'b111);

        // Broadcast with channel 1 blocked: nothing is sent and the frame aborts.
        wait_ready();
        cmd_data = 32'h0BADF00D; cmd_ch = 2'd3; cmd_valid = 1'b1; cur_ch = 2'd3;
        nTF = 3'b101;
        got.delete(); cyc = 0; err_cyc = -1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < STALL_MAX + 10 && err_cyc < 0; i++) begin
            step();
            if (err === 1'b1) err_cyc = cyc;
        end
        check("abort_err_timing", {31'd0, (err_cyc >= STALL_MAX + 1 && err_cyc <= STALL_MAX + 2)}, 32'd1);
        check("abort_no_bytes", got.size(), 0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_count", {16'd0, tx_count}, {16'd0, model_count});
        nTF = 3'b111;
        run_frame(32'h01020304, 2'd2, 0, 0, 0, 3'b111);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset while byte 56 is on the link; the frame must not resume.
        wait_ready();
        cmd_data = 32'h12345678; cmd_ch = 2'd0; cmd_valid = 1'b1; cur_ch = 2'd0;
        got.delete(); cyc = 0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && got.size() < 4; i++) step();
        check("pre_rst_byte", {24'd0, D}, 32'h56);
        #1 rst = 1'b1;
        #1;
        check("midrst_ntx", {31'd0, nTx}, 32'd1);
        check("midrst_d", {24'd0, D}, 32'h00);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        check("midrst_count", {16'd0, tx_count}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        @(posedge clk_100);
        @(negedge clk_100);
        rst = 1'b0;
        last_d = 8'h00;
        model_count = 16'h0000;
        got.delete();
        repeat (4) step();
        check("no_resume", got.size(), 0);
        run_frame(32'hA1B2C3D4, 2'd0, 0, 0, 0, 3'b111);

        // Counter wrap from 0xFFFF.
        force dut.tx_count = 16'hFFFF;
        #1 release dut.tx_count;
        model_count = 16'hFFFF;
        run_frame(32'h55AA55AA, 2'd1, 0, 0, 0, 3'b111);
        check("wrap_zero", {16'd0, tx_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
